stream_fifo_rv: RTL and testbench

Parametrised, fully registered stream FIFO: the generalised successor of the two-stage R+V stream buffer, with configurable depth, an occupancy count and an almost-full flag. It accepts one beat per cycle, sustains full throughput, and registers `in_ready`, `out_valid` and `out_data` so that it can sit between any two stream stages to break timing paths in both directions. It also adds elastic buffering for bursty producers.

---
 rtl/stream_fifo_rv.sv | 108 ++++++++++
 tb/tb_stream_fifo_rv.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo_rv.sv
// stream_fifo_rv: fully registered stream FIFO with occupancy count and
// almost-full flag. Storage is a (Depth-1)-entry circular buffer feeding a
// registered output stage; a push into an otherwise empty path bypasses the
// buffer and lands directly in the output register.
// Optional feature: define STREAM_FIFO_RV_FLUSH_EN to add a synchronous
// active-high `flush` input that empties the FIFO in one cycle.
module stream_fifo_rv #(
  parameter int unsigned DataBits        = 8,
  parameter int unsigned Depth           = 4,
  parameter int unsigned AlmostFullLevel = Depth - 1
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef STREAM_FIFO_RV_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DataBits-1:0]          in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DataBits-1:0]          out_data,
  output logic [$clog2(Depth+1)-1:0]   level,
  output logic                         almost_full
);

  localparam int unsigned LevelBits = $clog2(Depth + 1);
  localparam int unsigned BufDepth  = Depth - 1;
  localparam int unsigned PtrBits   = (BufDepth > 1) ? $clog2(BufDepth) : 1;
  localparam logic [PtrBits-1:0]   PtrLast   = PtrBits'(BufDepth - 1);
  localparam logic [LevelBits-1:0] LevelFull = LevelBits'(Depth);
  localparam logic [LevelBits-1:0] LevelAf   = LevelBits'(AlmostFullLevel);
  localparam logic [LevelBits-1:0] LevelOne  = LevelBits'(1);

  logic [DataBits-1:0]  mem [BufDepth];
  logic [PtrBits-1:0]   wr_ptr, rd_ptr, wr_ptr_inc, rd_ptr_inc;
  logic                 push, pop, clear;
  logic                 buf_empty, out_load, load_from_buf, bypass, buf_write;
  logic [LevelBits-1:0] level_next;

  // Handshakes, refill source selection and next occupancy.
  always_comb begin
    push = in_valid && in_ready;
    pop  = out_valid && out_ready;
`ifdef STREAM_FIFO_RV_FLUSH_EN
    clear = flush;
`else
    clear = 1'b0;
`endif
    // out_valid tracks level != 0, so the buffer holds level-1 beats when
    // the output register is occupied; it is empty whenever level <= 1.
    buf_empty     = (level <= LevelOne);
    out_load      = !out_valid || pop;
    load_from_buf = out_load && !buf_empty;
    bypass        = out_load && buf_empty && push;
    buf_write     = push && !bypass;
    wr_ptr_inc    = (wr_ptr == PtrLast) ? '0 : wr_ptr + PtrBits'(1);
    rd_ptr_inc    = (rd_ptr == PtrLast) ? '0 : rd_ptr + PtrBits'(1);
    level_next    = level;
    if (clear) begin
      level_next = '0;
    end else if (push && !pop) begin
      level_next = level + LevelOne;
    end else if (pop && !push) begin
      level_next = level - LevelOne;
    end
  end

  // Registered status flags, pointers and output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level       <= '0;
      in_ready    <= 1'b0;
      almost_full <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      level       <= level_next;
      in_ready    <= (level_next < LevelFull);
      almost_full <= (level_next >= LevelAf);
      out_valid   <= (level_next != '0);
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (buf_write) begin
          wr_ptr <= wr_ptr_inc;
        end
        if (load_from_buf) begin
          rd_ptr   <= rd_ptr_inc;
          out_data <= mem[rd_ptr];
        end else if (bypass) begin
          out_data <= in_data;
        end
      end
    end
  end

  // Buffer storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (buf_write && !clear) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_stream_fifo_rv.sv
// tb_stream_fifo_rv: directed and random scoreboard bench for stream_fifo_rv
// (Depth = 4, DataBits = 8).
module tb_stream_fifo_rv;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, almost_full;
  logic [7:0] in_data, out_data;
  logic [2:0] level;
  logic       flush_in;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] q[$];
  int         mlevel = 0;
  logic       last_push = 1'b0;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = '0;

  stream_fifo_rv #(.DataBits(8), .Depth(DEPTH), .AlmostFullLevel(DEPTH - 1)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef STREAM_FIFO_RV_FLUSH_EN
    .flush       (flush_in),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called just after a falling edge: drive, sample, update model, advance one cycle, check.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    logic push, pop;
    in_valid = iv; in_data = d; out_ready = ordy; flush_in = fl;
    #1;
    if (stall_prev) chk("stall_hold", {24'd0, out_data}, {24'd0, stall_data});
    if (out_valid && q.size() != 0) chk("head_data", {24'd0, out_data}, {24'd0, q[0]});
    push = in_valid && in_ready;
    pop  = out_valid && out_ready;
    last_push  = push;
    stall_prev = out_valid && !out_ready && !fl;
    stall_data = out_data;
    if (fl) begin
      q.delete();
      mlevel = 0;
    end else begin
      if (pop) begin
        if (q.size() != 0) void'(q.pop_front());
        mlevel--;
      end
      if (push) begin
        q.push_back(d);
        mlevel++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("level", {29'd0, level}, mlevel);
    chk("out_valid", {31'd0, out_valid}, {31'd0, mlevel != 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, mlevel < DEPTH});
    chk("almost_full", {31'd0, almost_full}, {31'd0, mlevel >= DEPTH - 1});
  endtask

  initial begin
    int cnt;
    int npush;
    logic got5;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush_in = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_level", {29'd0, level}, 0);
    chk("rst_almost_full", {31'd0, almost_full}, 0);
    chk("rst_out_data", {24'd0, out_data}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("release_in_ready", {31'd0, in_ready}, 1);

    // Single beat latency
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("single_valid", {31'd0, out_valid}, 1);
    chk("single_data", {24'd0, out_data}, 32'hA5);
    chk("single_level", {29'd0, level}, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill to full, then drain while offering 0x05
    for (int v = 1; v <= 4; v++) begin
      step(1'b1, 8'(v), 1'b0, 1'b0);
      chk("fill_accept", {31'd0, last_push}, 1);
    end
    chk("full_level", {29'd0, level}, 4);
    chk("full_in_ready", {31'd0, in_ready}, 0);
    step(1'b1, 8'h05, 1'b0, 1'b0);
    chk("full_reject", {31'd0, last_push}, 0);
    cnt = 0; got5 = 1'b0;
    while (!got5 && cnt < 20) begin
      step(1'b1, 8'h05, 1'b1, 1'b0);
      if (last_push) got5 = 1'b1;
      cnt++;
    end
    chk("accept_05", {31'd0, got5}, 1);
    cnt = 0;
    while (q.size() != 0 && cnt < 20) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      cnt++;
    end
    chk("fill_drained", q.size(), 0);

    // Streaming at full throughput
    step(1'b1, 8'($urandom), 1'b1, 1'b0);
    for (int i = 1; i < 1000; i++) begin
      step(1'b1, 8'($urandom), 1'b1, 1'b0);
      chk("stream_accept", {31'd0, last_push}, 1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random backpressure
    npush = 0; cnt = 0;
    while (npush < 10000 && cnt < 50000) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      if (last_push) npush++;
      cnt++;
    end
    chk("random_beats", npush, 10000);
    cnt = 0;
    while (q.size() != 0 && cnt < 20) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      cnt++;
    end
    chk("random_drained", q.size(), 0);

    // Asynchronous reset mid-burst at level 3
    for (int v = 1; v <= 3; v++) step(1'b1, 8'(8'h10 + v), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 0);
    chk("arst_out_valid", {31'd0, out_valid}, 0);
    chk("arst_level", {29'd0, level}, 0);
    chk("arst_almost_full", {31'd0, almost_full}, 0);
    chk("arst_out_data", {24'd0, out_data}, 0);
    q.delete(); mlevel = 0; stall_prev = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_release_ready", {31'd0, in_ready}, 1);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("arst_fresh_data", {24'd0, out_data}, 32'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef STREAM_FIFO_RV_FLUSH_EN
    // Flush at full with a simultaneous push attempt
    for (int v = 1; v <= 4; v++) step(1'b1, 8'(8'h40 + v), 1'b0, 1'b0);
    chk("flush_pre_level", {29'd0, level}, 4);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    chk("flush_level", {29'd0, level}, 0);
    chk("flush_out_valid", {31'd0, out_valid}, 0);
    chk("flush_in_ready", {31'd0, in_ready}, 1);
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
